// File: rtl/modinv_helper_invert_precalc_pkg.sv
// Shared constants and helpers for the modular-inverse helper blocks.
package modinv_helper_invert_precalc_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  // Number of bits needed to encode values 0..value-1.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

  // Length of one pass: idle slot, N reads, and two drain cycles.
  function automatic int proc_num_cycles(input int num_words);
    return num_words + 3;
  endfunction

endpackage

// File: rtl/modinv_helper_addsub32.sv
// 32-bit adder/subtractor with chained carry (add) or borrow (sub).
module modinv_helper_addsub32
  import modinv_helper_invert_precalc_pkg::*;
(
  input  word_t a,
  input  word_t b,
  input  logic  sub,
  input  logic  cb_in,
  output word_t y,
  output logic  cb_out
);

  logic [WORD_W:0] sum;
  word_t           b_eff;
  logic            c_in;

  // Subtraction is a + ~b + 1; the borrow is the inverted carry.
  always_comb begin
    b_eff  = sub ? ~b : b;
    c_in   = sub ? ~cb_in : cb_in;
    sum    = {1'b0, a} + {1'b0, b_eff} + {{WORD_W{1'b0}}, c_in};
    y      = sum[WORD_W-1:0];
    cb_out = sub ? ~sum[WORD_W] : sum[WORD_W];
  end

endmodule

// File: rtl/modinv_helper_invert_precalc.sv
// Precalculates 2r, 2s, r+s, u/2, v/2, (u-v)/2, (v-u)/2 word-serially,
// plus comparison flags on u and v for the inversion loop.
module modinv_helper_invert_precalc
  import modinv_helper_invert_precalc_pkg::*;
#(
  parameter int BUFFER_NUM_WORDS = 9,
  parameter int BUFFER_ADDR_BITS = 4
)(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ena,
  output logic                        rdy,
  output logic [BUFFER_ADDR_BITS-1:0] r_addr,
  output logic [BUFFER_ADDR_BITS-1:0] s_addr,
  output logic [BUFFER_ADDR_BITS-1:0] u_addr,
  output logic [BUFFER_ADDR_BITS-1:0] v_addr,
  input  logic [31:0]                 r_din,
  input  logic [31:0]                 s_din,
  input  logic [31:0]                 u_din,
  input  logic [31:0]                 v_din,
  output logic [BUFFER_ADDR_BITS-1:0] r_dbl_addr,
  output logic                        r_dbl_wren,
  output logic [31:0]                 r_dbl_dout,
  output logic [BUFFER_ADDR_BITS-1:0] s_dbl_addr,
  output logic                        s_dbl_wren,
  output logic [31:0]                 s_dbl_dout,
  output logic [BUFFER_ADDR_BITS-1:0] r_plus_s_addr,
  output logic                        r_plus_s_wren,
  output logic [31:0]                 r_plus_s_dout,
  output logic [BUFFER_ADDR_BITS-1:0] u_half_addr,
  output logic                        u_half_wren,
  output logic [31:0]                 u_half_dout,
  output logic [BUFFER_ADDR_BITS-1:0] v_half_addr,
  output logic                        v_half_wren,
  output logic [31:0]                 v_half_dout,
  output logic [BUFFER_ADDR_BITS-1:0] u_minus_v_half_addr,
  output logic                        u_minus_v_half_wren,
  output logic [31:0]                 u_minus_v_half_dout,
  output logic [BUFFER_ADDR_BITS-1:0] v_minus_u_half_addr,
  output logic                        v_minus_u_half_wren,
  output logic [31:0]                 v_minus_u_half_dout,
  output logic                        u_gt_v,
  output logic                        v_eq_1,
  output logic                        u_is_even,
  output logic                        v_is_even
);

  localparam int N               = BUFFER_NUM_WORDS;
  localparam int PROC_NUM_CYCLES = proc_num_cycles(N);
  localparam int CNT_W           = clog2(PROC_NUM_CYCLES);

  typedef logic [CNT_W-1:0]            cnt_t;
  typedef logic [BUFFER_ADDR_BITS-1:0] addr_t;

  localparam cnt_t CNT_ONE   = cnt_t'(1);
  localparam cnt_t CNT_TWO   = cnt_t'(2);
  localparam cnt_t CNT_THREE = cnt_t'(3);
  localparam cnt_t CNT_N     = cnt_t'(N);
  localparam cnt_t CNT_N1    = cnt_t'(N + 1);
  localparam cnt_t CNT_LAST  = cnt_t'(N + 2);

  cnt_t        proc_cnt_q, proc_cnt_d;
  logic        carry_rdbl_q, carry_rdbl_d;
  logic        carry_sdbl_q, carry_sdbl_d;
  logic        carry_rps_q, carry_rps_d;
  logic        borrow_uv_q, borrow_uv_d;
  logic        borrow_vu_q, borrow_vu_d;
  logic [30:0] u_prev_q, u_prev_d;
  logic [30:0] v_prev_q, v_prev_d;
  logic [30:0] uv_prev_q, uv_prev_d;
  logic [30:0] vu_prev_q, vu_prev_d;
  logic        u_lsb_q, u_lsb_d;
  logic        v_lsb_q, v_lsb_d;
  logic        v_one_q, v_one_d;
  logic        u_gt_v_q, u_gt_v_d;
  logic        v_eq_1_q, v_eq_1_d;
  logic        u_is_even_q, u_is_even_d;
  logic        v_is_even_q, v_is_even_d;

  logic  rd_act, full_act, del_act, is_first, is_last;
  addr_t rd_addr, full_addr, del_addr;
  word_t rps_sum, uv_diff, vu_diff;
  logic  rps_cout, uv_bout, vu_bout;
  logic  u_top, v_top, uv_top, vu_top;

  modinv_helper_addsub32 u_add_rs (
    .a(r_din), .b(s_din), .sub(1'b0), .cb_in(carry_rps_q), .y(rps_sum), .cb_out(rps_cout)
  );
  modinv_helper_addsub32 u_sub_uv (
    .a(u_din), .b(v_din), .sub(1'b1), .cb_in(borrow_uv_q), .y(uv_diff), .cb_out(uv_bout)
  );
  modinv_helper_addsub32 u_sub_vu (
    .a(v_din), .b(u_din), .sub(1'b1), .cb_in(borrow_vu_q), .y(vu_diff), .cb_out(vu_bout)
  );

  // Counter, phase decode, address generation and next-state of all registers.
  always_comb begin
    rd_act   = (proc_cnt_q >= CNT_ONE)   && (proc_cnt_q <= CNT_N);
    full_act = (proc_cnt_q >= CNT_TWO)   && (proc_cnt_q <= CNT_N1);
    del_act  = (proc_cnt_q >= CNT_THREE) && (proc_cnt_q <= CNT_LAST);
    is_first = (proc_cnt_q == CNT_ONE);
    is_last  = (proc_cnt_q == CNT_LAST);

    rd_addr   = rd_act   ? addr_t'(proc_cnt_q - CNT_ONE)   : '0;
    full_addr = full_act ? addr_t'(proc_cnt_q - CNT_TWO)   : '0;
    del_addr  = del_act  ? addr_t'(proc_cnt_q - CNT_THREE) : '0;

    if (proc_cnt_q == '0)  proc_cnt_d = ena ? CNT_ONE : '0;
    else if (is_last)      proc_cnt_d = '0;
    else                   proc_cnt_d = proc_cnt_q + CNT_ONE;

    carry_rdbl_d = carry_rdbl_q;
    carry_sdbl_d = carry_sdbl_q;
    carry_rps_d  = carry_rps_q;
    borrow_uv_d  = borrow_uv_q;
    borrow_vu_d  = borrow_vu_q;
    u_prev_d     = u_prev_q;
    v_prev_d     = v_prev_q;
    uv_prev_d    = uv_prev_q;
    vu_prev_d    = vu_prev_q;
    u_lsb_d      = u_lsb_q;
    v_lsb_d      = v_lsb_q;
    v_one_d      = v_one_q;
    if (is_first) begin
      carry_rdbl_d = 1'b0;
      carry_sdbl_d = 1'b0;
      carry_rps_d  = 1'b0;
      borrow_uv_d  = 1'b0;
      borrow_vu_d  = 1'b0;
    end else if (full_act) begin
      carry_rdbl_d = r_din[31];
      carry_sdbl_d = s_din[31];
      carry_rps_d  = rps_cout;
      borrow_uv_d  = uv_bout;
      borrow_vu_d  = vu_bout;
      u_prev_d     = u_din[31:1];
      v_prev_d     = v_din[31:1];
      uv_prev_d    = uv_diff[31:1];
      vu_prev_d    = vu_diff[31:1];
      if (proc_cnt_q == CNT_TWO) begin
        u_lsb_d = u_din[0];
        v_lsb_d = v_din[0];
        v_one_d = (v_din == 32'd1);
      end else begin
        v_one_d = v_one_q & (v_din == 32'd0);
      end
    end

    u_gt_v_d    = u_gt_v_q;
    v_eq_1_d    = v_eq_1_q;
    u_is_even_d = u_is_even_q;
    v_is_even_d = v_is_even_q;
    if (is_last) begin
      u_gt_v_d    = borrow_vu_q;
      v_eq_1_d    = v_one_q;
      u_is_even_d = ~u_lsb_q;
      v_is_even_d = ~v_lsb_q;
    end

    // The word above N-1 does not exist, so the shifted-in bit is zero there.
    u_top  = is_last ? 1'b0 : u_din[0];
    v_top  = is_last ? 1'b0 : v_din[0];
    uv_top = is_last ? 1'b0 : uv_diff[0];
    vu_top = is_last ? 1'b0 : vu_diff[0];
  end

  // State registers; reset clears the counter, flags, carries and pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      proc_cnt_q   <= '0;
      carry_rdbl_q <= 1'b0;
      carry_sdbl_q <= 1'b0;
      carry_rps_q  <= 1'b0;
      borrow_uv_q  <= 1'b0;
      borrow_vu_q  <= 1'b0;
      u_prev_q     <= '0;
      v_prev_q     <= '0;
      uv_prev_q    <= '0;
      vu_prev_q    <= '0;
      u_lsb_q      <= 1'b0;
      v_lsb_q      <= 1'b0;
      v_one_q      <= 1'b0;
      u_gt_v_q     <= 1'b0;
      v_eq_1_q     <= 1'b0;
      u_is_even_q  <= 1'b0;
      v_is_even_q  <= 1'b0;
    end else begin
      proc_cnt_q   <= proc_cnt_d;
      carry_rdbl_q <= carry_rdbl_d;
      carry_sdbl_q <= carry_sdbl_d;
      carry_rps_q  <= carry_rps_d;
      borrow_uv_q  <= borrow_uv_d;
      borrow_vu_q  <= borrow_vu_d;
      u_prev_q     <= u_prev_d;
      v_prev_q     <= v_prev_d;
      uv_prev_q    <= uv_prev_d;
      vu_prev_q    <= vu_prev_d;
      u_lsb_q      <= u_lsb_d;
      v_lsb_q      <= v_lsb_d;
      v_one_q      <= v_one_d;
      u_gt_v_q     <= u_gt_v_d;
      v_eq_1_q     <= v_eq_1_d;
      u_is_even_q  <= u_is_even_d;
      v_is_even_q  <= v_is_even_d;
    end
  end

  assign rdy    = (proc_cnt_q == '0);
  assign r_addr = rd_addr;
  assign s_addr = rd_addr;
  assign u_addr = rd_addr;
  assign v_addr = rd_addr;

  assign r_dbl_addr    = full_addr;
  assign r_dbl_wren    = full_act;
  assign r_dbl_dout    = {r_din[30:0], carry_rdbl_q};
  assign s_dbl_addr    = full_addr;
  assign s_dbl_wren    = full_act;
  assign s_dbl_dout    = {s_din[30:0], carry_sdbl_q};
  assign r_plus_s_addr = full_addr;
  assign r_plus_s_wren = full_act;
  assign r_plus_s_dout = rps_sum;

  assign u_half_addr         = del_addr;
  assign u_half_wren         = del_act;
  assign u_half_dout         = {u_top, u_prev_q};
  assign v_half_addr         = del_addr;
  assign v_half_wren         = del_act;
  assign v_half_dout         = {v_top, v_prev_q};
  assign u_minus_v_half_addr = del_addr;
  assign u_minus_v_half_wren = del_act;
  assign u_minus_v_half_dout = {uv_top, uv_prev_q};
  assign v_minus_u_half_addr = del_addr;
  assign v_minus_u_half_wren = del_act;
  assign v_minus_u_half_dout = {vu_top, vu_prev_q};

  assign u_gt_v    = u_gt_v_q;
  assign v_eq_1    = v_eq_1_q;
  assign u_is_even = u_is_even_q;
  assign v_is_even = v_is_even_q;

endmodule

// File: tb/tb_modinv_helper_invert_precalc.sv
// Bench for modinv_helper_invert_precalc: table vectors, random operands
// against a big-integer model, reset abort, busy-time ena and back-to-back.
module tb_modinv_helper_invert_precalc;

  localparam int N  = 9;
  localparam int AW = 4;
  localparam int W  = 32 * N;

  logic clk, rst, ena, rdy;
  logic [AW-1:0] r_addr, s_addr, u_addr, v_addr;
  logic [31:0] r_din, s_din, u_din, v_din;
  logic [AW-1:0] r_dbl_addr, s_dbl_addr, r_plus_s_addr;
  logic          r_dbl_wren, s_dbl_wren, r_plus_s_wren;
  logic [31:0]   r_dbl_dout, s_dbl_dout, r_plus_s_dout;
  logic [AW-1:0] u_half_addr, v_half_addr, umvh_addr, vmuh_addr;
  logic          u_half_wren, v_half_wren, umvh_wren, vmuh_wren;
  logic [31:0]   u_half_dout, v_half_dout, umvh_dout, vmuh_dout;
  logic u_gt_v, v_eq_1, u_is_even, v_is_even;

  modinv_helper_invert_precalc #(.BUFFER_NUM_WORDS(N), .BUFFER_ADDR_BITS(AW)) dut (
    .clk(clk), .rst(rst), .ena(ena), .rdy(rdy),
    .r_addr(r_addr), .s_addr(s_addr), .u_addr(u_addr), .v_addr(v_addr),
    .r_din(r_din), .s_din(s_din), .u_din(u_din), .v_din(v_din),
    .r_dbl_addr(r_dbl_addr), .r_dbl_wren(r_dbl_wren), .r_dbl_dout(r_dbl_dout),
    .s_dbl_addr(s_dbl_addr), .s_dbl_wren(s_dbl_wren), .s_dbl_dout(s_dbl_dout),
    .r_plus_s_addr(r_plus_s_addr), .r_plus_s_wren(r_plus_s_wren), .r_plus_s_dout(r_plus_s_dout),
    .u_half_addr(u_half_addr), .u_half_wren(u_half_wren), .u_half_dout(u_half_dout),
    .v_half_addr(v_half_addr), .v_half_wren(v_half_wren), .v_half_dout(v_half_dout),
    .u_minus_v_half_addr(umvh_addr), .u_minus_v_half_wren(umvh_wren),
    .u_minus_v_half_dout(umvh_dout),
    .v_minus_u_half_addr(vmuh_addr), .v_minus_u_half_wren(vmuh_wren),
    .v_minus_u_half_dout(vmuh_dout),
    .u_gt_v(u_gt_v), .v_eq_1(v_eq_1), .u_is_even(u_is_even), .v_is_even(v_is_even)
  );

  always #5 clk = ~clk;

  // Source banks with one cycle of read latency.
  logic [31:0] r_mem [N];
  logic [31:0] s_mem [N];
  logic [31:0] u_mem [N];
  logic [31:0] v_mem [N];

  always @(posedge clk) begin
    r_din <= (r_addr < AW'(N)) ? r_mem[r_addr] : 32'hDEADBEEF;
    s_din <= (s_addr < AW'(N)) ? s_mem[s_addr] : 32'hDEADBEEF;
    u_din <= (u_addr < AW'(N)) ? u_mem[u_addr] : 32'hDEADBEEF;
    v_din <= (v_addr < AW'(N)) ? v_mem[v_addr] : 32'hDEADBEEF;
  end

  // Destination groups: 0 r_dbl, 1 s_dbl, 2 r_plus_s, 3 u_half, 4 v_half, 5 (u-v)/2, 6 (v-u)/2
  logic [6:0]    wen;
  logic [AW-1:0] wad [7];
  logic [31:0]   wdo [7];
  assign wen = {vmuh_wren, umvh_wren, v_half_wren, u_half_wren,
                r_plus_s_wren, s_dbl_wren, r_dbl_wren};
  assign wad[0] = r_dbl_addr;   assign wdo[0] = r_dbl_dout;
  assign wad[1] = s_dbl_addr;   assign wdo[1] = s_dbl_dout;
  assign wad[2] = r_plus_s_addr; assign wdo[2] = r_plus_s_dout;
  assign wad[3] = u_half_addr;  assign wdo[3] = u_half_dout;
  assign wad[4] = v_half_addr;  assign wdo[4] = v_half_dout;
  assign wad[5] = umvh_addr;    assign wdo[5] = umvh_dout;
  assign wad[6] = vmuh_addr;    assign wdo[6] = vmuh_dout;

  logic [31:0] ob [7][N];
  int wcnt [7];
  int viol;
  int total, bad;

  typedef struct {
    logic [W-1:0] u, v, r, s;
    logic [W-1:0] e_u_half, e_r_plus_s, e_r_dbl;
    logic [3:0]   e_flags;  // {u_gt_v, v_eq_1, u_is_even, v_is_even}
  } vec_t;

  vec_t tbl [5];

  function automatic vec_t mk(input logic [W-1:0] u, v, r, s, euh, erps, erdbl,
                              input logic [3:0] ef);
    vec_t t;
    t.u = u; t.v = v; t.r = r; t.s = s;
    t.e_u_half = euh; t.e_r_plus_s = erps; t.e_r_dbl = erdbl; t.e_flags = ef;
    return t;
  endfunction

  // Advance to the next falling edge and record any writes seen there.
  task automatic tick();
    @(negedge clk);
    for (int g = 0; g < 7; g++) begin
      if (wen[g]) begin
        wcnt[g]++;
        if (wad[g] < AW'(N)) ob[g][wad[g]] = wdo[g];
        else viol++;
      end
    end
    if (rdy && (wen != 7'd0)) viol++;
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load(input logic [W-1:0] u, v, r, s);
    for (int i = 0; i < N; i++) begin
      u_mem[i] = u[32*i +: 32];
      v_mem[i] = v[32*i +: 32];
      r_mem[i] = r[32*i +: 32];
      s_mem[i] = s[32*i +: 32];
    end
  endtask

  task automatic clear_mon();
    for (int g = 0; g < 7; g++) begin
      wcnt[g] = 0;
      for (int i = 0; i < N; i++) ob[g][i] = 32'h0;
    end
  endtask

  function automatic logic [W-1:0] get_buf(input int g);
    logic [W-1:0] res;
    for (int i = 0; i < N; i++) res[32*i +: 32] = ob[g][i];
    return res;
  endfunction

  function automatic logic [W-1:0] rnd_big();
    logic [W-1:0] res;
    for (int i = 0; i < N; i++) res[32*i +: 32] = $urandom;
    return res;
  endfunction

  function automatic logic [3:0] cur_flags();
    return {u_gt_v, v_eq_1, u_is_even, v_is_even};
  endfunction

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!rdy && n < 40) begin
      tick();
      n++;
    end
    chk({name, " idle"}, W'(rdy), W'(1));
  endtask

  task automatic run_pass(input string name, input logic [W-1:0] u, v, r, s);
    load(u, v, r, s);
    clear_mon();
    ena = 1'b1;
    tick();
    ena = 1'b0;
    wait_idle(name);
  endtask

  // Reference: plain big-integer arithmetic modulo 2^W.
  task automatic check_model(input string name, input logic [W-1:0] u, v, r, s,
                             input int exp_wr);
    logic [W-1:0] e [7];
    logic [3:0]   ef;
    e[0] = r << 1;
    e[1] = s << 1;
    e[2] = r + s;
    e[3] = u >> 1;
    e[4] = v >> 1;
    e[5] = (u - v) >> 1;
    e[6] = (v - u) >> 1;
    ef = {u > v, v == W'(1), ~u[0], ~v[0]};
    for (int g = 0; g < 7; g++) begin
      chk($sformatf("%s buf%0d", name, g), get_buf(g), e[g]);
      chk($sformatf("%s wcnt%0d", name, g), W'(wcnt[g]), W'(exp_wr));
    end
    chk({name, " flags"}, W'(cur_flags()), W'(ef));
  endtask

  initial begin
    logic [W-1:0] ru, rv, rr, rs, bu, bv, br, bs;
    int busy, n, phase;
    clk = 1'b0; rst = 1'b1; ena = 1'b0;
    total = 0; bad = 0; viol = 0;
    load('0, '0, '0, '0);
    clear_mon();

    tbl[0] = mk(W'(6), W'(3), W'(1), W'(0), W'(3), W'(1), W'(2), 4'b1010);
    tbl[1] = mk(W'(0), W'(0), W'(32'hFFFFFFFF), W'(32'hFFFFFFFF),
                W'(0), W'(64'h1_FFFF_FFFE), W'(64'h1_FFFF_FFFE), 4'b0011);
    tbl[2] = mk(W'(1) << 32, W'(0), W'(0), W'(0),
                W'(32'h80000000), W'(0), W'(0), 4'b1011);
    tbl[3] = mk(W'(1), W'(1), W'(0), W'(0), W'(0), W'(0), W'(0), 4'b0100);
    tbl[4] = mk(W'(1), (W'(1) << 256) | W'(1), W'(0), W'(0),
                W'(0), W'(0), W'(0), 4'b0000);

    tick();
    tick();
    rst = 1'b0;
    viol = 0;
    chk("reset rdy", W'(rdy), W'(1));
    chk("reset wren", W'(wen), W'(0));
    chk("reset flags", W'(cur_flags()), W'(0));

    for (int k = 0; k < 5; k++) begin
      string nm;
      nm = $sformatf("vec%0d", k);
      run_pass(nm, tbl[k].u, tbl[k].v, tbl[k].r, tbl[k].s);
      chk({nm, " u_half"}, get_buf(3), tbl[k].e_u_half);
      chk({nm, " r_plus_s"}, get_buf(2), tbl[k].e_r_plus_s);
      chk({nm, " r_dbl"}, get_buf(0), tbl[k].e_r_dbl);
      chk({nm, " tbl_flags"}, W'(cur_flags()), W'(tbl[k].e_flags));
      check_model(nm, tbl[k].u, tbl[k].v, tbl[k].r, tbl[k].s, N);
    end

    for (int k = 0; k < 8; k++) begin
      string nm;
      nm = $sformatf("rnd%0d", k);
      ru = rnd_big(); rv = rnd_big(); rr = rnd_big(); rs = rnd_big();
      if (k % 3 == 0) rv = W'($urandom_range(0, 3));
      if (k % 4 == 1) rv = ru;
      run_pass(nm, ru, rv, rr, rs);
      check_model(nm, ru, rv, rr, rs, N);
    end

    // Abort a pass with reset at proc_cnt=5.
    run_pass("pre_abort", W'(6), W'(3), W'(1), W'(0));
    load(W'(1), W'(1), W'(0), W'(0));
    clear_mon();
    ena = 1'b1;
    tick();
    ena = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("busy rdy", W'(rdy), W'(0));
    chk("flags held busy", W'(cur_flags()), W'(4'b1010));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort rdy", W'(rdy), W'(1));
    chk("abort wren", W'(wen), W'(0));
    chk("abort flags", W'(cur_flags()), W'(0));
    for (int i = 0; i < 3; i++) tick();
    chk("abort still idle", W'(rdy), W'(1));

    // ena pulses during a pass must not disturb its length.
    ru = rnd_big(); rv = rnd_big(); rr = rnd_big(); rs = rnd_big();
    load(ru, rv, rr, rs);
    clear_mon();
    ena = 1'b1;
    tick();
    busy = 1;
    while (!rdy && busy < 40) begin
      ena = (busy == 2 || busy == 5);
      tick();
      if (!rdy) busy++;
    end
    ena = 1'b0;
    chk("busy cycles", W'(busy), W'(N + 2));
    check_model("ena_busy", ru, rv, rr, rs, N);

    // Back-to-back passes with ena held; banks swapped in the idle slot.
    ru = rnd_big(); rv = rnd_big(); rr = rnd_big(); rs = rnd_big();
    bu = rnd_big(); bv = W'(1); br = rnd_big(); bs = rnd_big();
    bu[0] = 1'b0;
    load(ru, rv, rr, rs);
    clear_mon();
    ena = 1'b1;
    tick();
    n = 0;
    phase = 0;
    while (n < 80 && phase < 3) begin
      tick();
      n++;
      if (phase == 0 && rdy) begin
        load(bu, bv, br, bs);
        phase = 1;
      end else if (phase == 1 && !rdy) begin
        ena = 1'b0;
        phase = 2;
      end else if (phase == 2 && rdy) begin
        phase = 3;
      end
    end
    ena = 1'b0;
    chk("b2b done", W'(phase), W'(3));
    chk("b2b cycles", W'(n), W'(2 * (N + 2) + 1));
    check_model("b2b", bu, bv, br, bs, 2 * N);

    for (int i = 0; i < 3; i++) tick();
    chk("write violations", W'(viol), W'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
